// File: rtl/pattern_link_pkg.sv
// Shared definitions for the 10110 pattern link: transmitter state encoding
// and the sync header used by both the transmitter and the detector.
package pattern_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_GAP
  } link_state_e;

  localparam int                    SYNC_W_DEF   = 5;
  localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = 5'b10110;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_period_div.sv
// Divides the clock into serial bit periods of BIT_DIV clocks each.
// Held at zero while idle, so the first active clock always starts a period.
module bit_period_div #(
  parameter int BIT_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic last,
  output logic start_nxt
);

  localparam int               DIV_W    = $clog2(BIT_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign last      = (cnt == DIV_LAST);
  // next clock is the first of a bit period
  assign start_nxt = !run || last;

  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (!run || last)  cnt <= '0;
    else                    cnt <= cnt + DIV_W'(1);
  end

endmodule

// File: rtl/pattern_frame_tx.sv
// Frame serializer for the pattern link: sync header, MSB-first payload,
// then an idle gap, emitted as a bit stream with a per-bit valid strobe.
module pattern_frame_tx
  import pattern_link_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
  parameter int                BIT_DIV  = 1,
  parameter int                GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              load_i,
  output logic              ready_o,
  output logic              d_o,
  output logic              valid_o,
  output logic              frame_done_o,
  output logic              busy_o
);

  localparam int CNT_MAX = max2(SYNC_W, DATA_W);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int GAP_W   = $clog2(GAP_BITS + 1) + 1;

  localparam logic [CNT_W-1:0] SYNC_TOP = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_TOP = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  link_state_e       state, nstate;
  logic [CNT_W-1:0]  bit_cnt, nbit;
  logic [GAP_W-1:0]  gap_cnt, ngap;
  logic [DATA_W-1:0] shift_reg, nshift;
  logic              d_nxt, v_nxt, fd_nxt;
  logic              per_last, per_start_nxt;

  bit_period_div #(.BIT_DIV(BIT_DIV)) u_div (
    .clk       (clk),
    .rst       (rst),
    .run       (state != ST_IDLE),
    .last      (per_last),
    .start_nxt (per_start_nxt)
  );

  assign ready_o = (state == ST_IDLE);
  assign busy_o  = (state != ST_IDLE);

  always_comb begin
    nstate = state;
    nbit   = bit_cnt;
    ngap   = gap_cnt;
    nshift = shift_reg;
    case (state)
      ST_IDLE: begin
        if (load_i) begin
          nshift = data_i;
          nbit   = SYNC_TOP;
          nstate = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (per_last) begin
          if (bit_cnt == '0) begin
            nbit   = DATA_TOP;
            nstate = ST_PAYLOAD;
          end else begin
            nbit = bit_cnt - CNT_W'(1);
          end
        end
      end
      ST_PAYLOAD: begin
        if (per_last) begin
          if (bit_cnt == '0) begin
            ngap   = '0;
            nstate = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
          end else begin
            nbit = bit_cnt - CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (per_last) begin
          if (gap_cnt == GAP_LAST) nstate = ST_IDLE;
          else                     ngap   = gap_cnt + GAP_W'(1);
        end
      end
      default: nstate = ST_IDLE;
    endcase

    // outputs are registered from the next state so they line up with it
    d_nxt  = 1'b0;
    if (nstate == ST_SYNC)         d_nxt = SYNC_PAT[nbit];
    else if (nstate == ST_PAYLOAD) d_nxt = nshift[nbit];
    v_nxt  = ((nstate == ST_SYNC) || (nstate == ST_PAYLOAD)) && per_start_nxt;
    fd_nxt = (nstate == ST_PAYLOAD) && (nbit == '0) && per_start_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      shift_reg    <= '0;
      d_o          <= 1'b0;
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      state        <= nstate;
      bit_cnt      <= nbit;
      gap_cnt      <= ngap;
      shift_reg    <= nshift;
      d_o          <= d_nxt;
      valid_o      <= v_nxt;
      frame_done_o <= fd_nxt;
    end
  end

endmodule

// File: tb/tb_pattern_frame_tx.sv
// Randomized check of three transmitter configurations against an
// arithmetic frame-timing model, plus a 10110 detector on the stream.
module tb_pattern_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s[3], load_s[3];
  logic [7:0] data_s[3];
  logic       d_s[3], v_s[3], fd_s[3], busy_s[3], rdy_s[3];

  pattern_frame_tx #(.DATA_W(8), .SYNC_W(5), .SYNC_PAT(5'b10110), .BIT_DIV(1), .GAP_BITS(2)) u_d0 (
    .clk(clk), .rst(rst_s[0]), .data_i(data_s[0]), .load_i(load_s[0]), .ready_o(rdy_s[0]),
    .d_o(d_s[0]), .valid_o(v_s[0]), .frame_done_o(fd_s[0]), .busy_o(busy_s[0]));
  pattern_frame_tx #(.DATA_W(8), .SYNC_W(5), .SYNC_PAT(5'b10110), .BIT_DIV(3), .GAP_BITS(2)) u_d1 (
    .clk(clk), .rst(rst_s[1]), .data_i(data_s[1]), .load_i(load_s[1]), .ready_o(rdy_s[1]),
    .d_o(d_s[1]), .valid_o(v_s[1]), .frame_done_o(fd_s[1]), .busy_o(busy_s[1]));
  pattern_frame_tx #(.DATA_W(8), .SYNC_W(5), .SYNC_PAT(5'b10110), .BIT_DIV(1), .GAP_BITS(0)) u_d2 (
    .clk(clk), .rst(rst_s[2]), .data_i(data_s[2]), .load_i(load_s[2]), .ready_o(rdy_s[2]),
    .d_o(d_s[2]), .valid_o(v_s[2]), .frame_done_o(fd_s[2]), .busy_o(busy_s[2]));

  int bd[3] = '{1, 3, 1};
  int gp[3] = '{2, 2, 0};

  // model: clock offset since accept (1-based) and the word latched at accept
  bit         act[3];
  int         ofs[3];
  logic [7:0] word[3];

  logic       ld[3], rs[3];
  logic [7:0] dat[3];

  logic [4:0] dsr;
  int         dn, bidx, hits, hit_idx;

  int checks = 0, failures = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input int b, input logic [7:0] w);
    logic [4:0] sp;
    sp = 5'b10110;
    if (b < 5) return sp[4-b];
    return w[7-(b-5)];
  endfunction

  task automatic cycle();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      int   t, b;
      logic ed, ev, efd, eb;
      ed = 1'b0; ev = 1'b0; efd = 1'b0; eb = 1'b0;
      if (act[i]) begin
        eb = 1'b1;
        t  = ofs[i] - 1;
        if (t < 13 * bd[i]) begin
          b   = t / bd[i];
          ev  = ((t % bd[i]) == 0);
          ed  = exp_bit(b, word[i]);
          efd = ev && (b == 12);
        end
      end
      chk($sformatf("c%0d u%0d d_o", cyc, i),    32'(d_s[i]),    32'(ed));
      chk($sformatf("c%0d u%0d valid", cyc, i),  32'(v_s[i]),    32'(ev));
      chk($sformatf("c%0d u%0d done", cyc, i),   32'(fd_s[i]),   32'(efd));
      chk($sformatf("c%0d u%0d busy", cyc, i),   32'(busy_s[i]), 32'(eb));
      chk($sformatf("c%0d u%0d ready", cyc, i),  32'(rdy_s[i]),  32'(!eb));
    end

    // non-overlapping 10110 detector on instance 0's strobed bits
    if (v_s[0]) begin
      dsr = {dsr[3:0], d_s[0]};
      dn++;
      bidx++;
      if (dn >= 5 && dsr == 5'b10110) begin
        hits++;
        hit_idx = bidx;
        dn = 0;
      end
    end

    for (int i = 0; i < 3; i++) begin
      if (rs[i]) begin
        act[i] = 1'b0;
      end else if (!act[i] && ld[i]) begin
        act[i]  = 1'b1;
        ofs[i]  = 1;
        word[i] = dat[i];
        if (i == 0) begin dsr = '0; dn = 0; bidx = 0; end
      end else if (act[i]) begin
        ofs[i]++;
        if (ofs[i] > (13 + gp[i]) * bd[i]) act[i] = 1'b0;
      end
      rst_s[i]  = rs[i];
      load_s[i] = ld[i];
      data_s[i] = dat[i];
    end
  endtask

  initial begin
    dsr = '0; dn = 0; bidx = 0; hits = 0; hit_idx = 0;
    for (int i = 0; i < 3; i++) begin
      rs[i] = 1'b1; ld[i] = 1'b0; dat[i] = '0; act[i] = 1'b0; ofs[i] = 0; word[i] = '0;
      rst_s[i] = 1'b1; load_s[i] = 1'b0; data_s[i] = '0;
    end
    repeat (3) @(posedge clk);
    for (int i = 0; i < 3; i++) rs[i] = 1'b0;
    cycle();

    // directed words; data keeps changing while frames are in flight
    ld = '{1'b1, 1'b1, 1'b1};
    dat = '{8'hA5, 8'hFF, 8'h3C};
    cycle();
    ld = '{1'b0, 1'b0, 1'b0};
    repeat (46) begin
      for (int i = 0; i < 3; i++) dat[i] = 8'($urandom);
      cycle();
    end

    // load held high: one accept per frame, back-to-back spacing
    repeat (120) begin
      for (int i = 0; i < 3; i++) begin ld[i] = 1'b1; dat[i] = 8'($urandom); end
      cycle();
    end
    ld = '{1'b0, 1'b0, 1'b0};
    repeat (50) cycle();

    // all-zero payload: detector sees exactly the sync header
    hits = 0; hit_idx = 0;
    ld[0] = 1'b1; dat[0] = 8'h00;
    cycle();
    ld[0] = 1'b0;
    repeat (16) cycle();
    chk("det_hits", 32'(hits), 32'd1);
    chk("det_idx", 32'(hit_idx), 32'd5);

    // reset during the third payload bit, then a fresh frame
    ld[0] = 1'b1; dat[0] = 8'($urandom);
    cycle();
    ld[0] = 1'b0;
    repeat (7) cycle();
    rs[0] = 1'b1;
    cycle();
    rs[0] = 1'b0;
    repeat (4) cycle();
    ld[0] = 1'b1; dat[0] = 8'($urandom);
    cycle();
    ld[0] = 1'b0;
    repeat (20) cycle();

    repeat (1500) begin
      for (int i = 0; i < 3; i++) begin
        ld[i]  = ($urandom_range(0, 2) == 0);
        dat[i] = 8'($urandom);
        rs[i]  = ($urandom_range(0, 79) == 0);
      end
      cycle();
    end
    for (int i = 0; i < 3; i++) begin ld[i] = 1'b0; rs[i] = 1'b0; end
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
